eq_band_mixer: RTL and testbench

- Parametrised, time-multiplexed successor of the equalizer gain/sum stage.
- Takes one sample per band from the filter bank, weights each by a per-band gain with one shared MAC, sums, saturates, and emits one output sample.
- Per-band gains are written through a register port and ramp smoothly toward their target once per output sample, which avoids zipper noise.
- Sits between the FIR filter bank and the audio output path.

---
 rtl/eq_defs.sv | 47 ++++
 rtl/eq_gain_ramp.sv | 74 +++++++
 rtl/eq_band_mixer.sv | 138 +++++++++++++
 tb/tb_eq_band_mixer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/eq_defs.sv
// ---------------------------------------------------------------------------
// eq_defs : shared definitions for the equalizer blocks.
//   - eq_state_e   : sequencing states of the band mixer (IDLE, MAC, OUT)
//   - unity_gain() : gain value equal to 1.0 for a given number of fraction bits
//   - clog2()      : ceiling log2 for parameter arithmetic
//   - sat_to_width(): clamp a signed value into a narrower signed range
// ---------------------------------------------------------------------------
package eq_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } eq_state_e;

    // Widest value sat_to_width() can take; callers sign-extend into it.
    localparam int unsigned SAT_W = 64;

    function automatic int unsigned unity_gain(input int unsigned frac);
        return 32'd1 << frac;
    endfunction

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Clamp v to [-2^(w-1), 2^(w-1)-1]; result stays SAT_W wide so the
    // caller can both truncate it and compare it against the input.
    function automatic logic signed [SAT_W-1:0] sat_to_width(
        input logic signed [SAT_W-1:0] v,
        input int unsigned             w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

endpackage

// File: rtl/eq_gain_ramp.sv
// ---------------------------------------------------------------------------
// eq_gain_ramp : per-band target/current gain register file.
//   clk, rst_n   : clock, asynchronous active-low reset (gains -> unity)
//   we_i/addr_i/wdata_i : target gain write port; addr_i >= N_BANDS ignored
//   ramp_i       : once-per-sample strobe; each current gain moves toward its
//                  target by at most RAMP_STEP (0 = jump straight to target)
//   rd_idx_i/rd_gain_o : current-gain read mux
// ---------------------------------------------------------------------------
module eq_gain_ramp
    import eq_defs::*;
#(
    parameter int unsigned N_BANDS   = 10,
    parameter int unsigned GAIN_W    = 13,
    parameter int unsigned GAIN_FRAC = 8,
    parameter int unsigned RAMP_STEP = 16,
    parameter int unsigned AW        = clog2(N_BANDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [GAIN_W-1:0] wdata_i,
    input  logic              ramp_i,
    input  logic [AW-1:0]     rd_idx_i,
    output logic [GAIN_W-1:0] rd_gain_o
);

    localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(unity_gain(GAIN_FRAC));
    localparam logic [GAIN_W-1:0] STEP  = GAIN_W'(RAMP_STEP);

    logic [GAIN_W-1:0] tgt_q [N_BANDS];
    logic [GAIN_W-1:0] tgt_d [N_BANDS];
    logic [GAIN_W-1:0] cur_q [N_BANDS];
    logic [GAIN_W-1:0] cur_d [N_BANDS];

    // The ramp reads tgt_q, so a write landing on the strobe cycle only
    // takes effect at the following strobe.
    always_comb begin
        for (int unsigned k = 0; k < N_BANDS; k++) begin
            tgt_d[k] = tgt_q[k];
            cur_d[k] = cur_q[k];
            if (we_i && (32'(addr_i) == k)) tgt_d[k] = wdata_i;
            if (ramp_i) begin
                if (RAMP_STEP == 0) begin
                    cur_d[k] = tgt_q[k];
                end else if (tgt_q[k] > cur_q[k]) begin
                    cur_d[k] = ((tgt_q[k] - cur_q[k]) <= STEP) ? tgt_q[k] : cur_q[k] + STEP;
                end else begin
                    cur_d[k] = ((cur_q[k] - tgt_q[k]) <= STEP) ? tgt_q[k] : cur_q[k] - STEP;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < N_BANDS; k++) begin
                tgt_q[k] <= UNITY;
                cur_q[k] <= UNITY;
            end
        end else begin
            tgt_q <= tgt_d;
            cur_q <= cur_d;
        end
    end

    always_comb begin
        rd_gain_o = '0;
        for (int unsigned k = 0; k < N_BANDS; k++) begin
            if (32'(rd_idx_i) == k) rd_gain_o = cur_q[k];
        end
    end

endmodule

// File: rtl/eq_band_mixer.sv
// ---------------------------------------------------------------------------
// eq_band_mixer : weights each band sample by its ramped gain on one shared
// MAC, sums, saturates and emits one output sample per input set.
//   clk, rst_n          : clock, asynchronous active-low reset
//   band_in, in_valid   : packed signed band samples (band k at k*SAMPLE_W)
//   in_ready            : high in IDLE only; no input buffering
//   gain_we/addr/wdata  : target gain write port (any state)
//   audio_out, out_valid, clip : saturated sum, 1-cycle strobe, clamp flag
// Accept at edge 0 -> out_valid after edge N_BANDS+1; period N_BANDS+2.
// ---------------------------------------------------------------------------
module eq_band_mixer
    import eq_defs::*;
#(
    parameter int unsigned N_BANDS   = 10,
    parameter int unsigned SAMPLE_W  = 24,
    parameter int unsigned GAIN_W    = 13,
    parameter int unsigned GAIN_FRAC = 8,
    parameter int unsigned RAMP_STEP = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_BANDS*SAMPLE_W-1:0]   band_in,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          gain_we,
    input  logic [clog2(N_BANDS)-1:0]     gain_addr,
    input  logic [GAIN_W-1:0]             gain_wdata,
    output logic signed [SAMPLE_W-1:0]    audio_out,
    output logic                          out_valid,
    output logic                          clip
);

    localparam int unsigned AW     = clog2(N_BANDS);
    localparam int unsigned ACC_W  = SAMPLE_W + GAIN_W + AW + 1;
    localparam int unsigned PROD_W = SAMPLE_W + GAIN_W + 1;

    eq_state_e                     state_q, state_d;
    logic [N_BANDS*SAMPLE_W-1:0]   band_q, band_d;
    logic signed [ACC_W-1:0]       acc_q, acc_d;
    logic [AW-1:0]                 idx_q, idx_d;
    logic signed [SAMPLE_W-1:0]    audio_q, audio_d;
    logic                          clip_q, clip_d;
    logic                          out_valid_q, out_valid_d;

    logic [GAIN_W-1:0]             cur_gain;
    logic signed [SAMPLE_W-1:0]    smp;
    logic signed [PROD_W-1:0]      prod;
    logic signed [ACC_W-1:0]       term;
    logic signed [SAT_W-1:0]       acc_ext;
    logic signed [SAT_W-1:0]       sat_v;

    // Ramp strobe is the OUT state, so gains only move between samples.
    eq_gain_ramp #(
        .N_BANDS   (N_BANDS),
        .GAIN_W    (GAIN_W),
        .GAIN_FRAC (GAIN_FRAC),
        .RAMP_STEP (RAMP_STEP),
        .AW        (AW)
    ) u_gain (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_i      (gain_we),
        .addr_i    (gain_addr),
        .wdata_i   (gain_wdata),
        .ramp_i    (state_q == OUT),
        .rd_idx_i  (idx_q),
        .rd_gain_o (cur_gain)
    );

    always_comb begin
        state_d     = state_q;
        band_d      = band_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        audio_d     = audio_q;
        clip_d      = clip_q;
        out_valid_d = 1'b0;

        smp = '0;
        for (int unsigned k = 0; k < N_BANDS; k++) begin
            if (32'(idx_q) == k) smp = band_q[k*SAMPLE_W +: SAMPLE_W];
        end
        // Gain is unsigned: zero-extend by one bit before the signed multiply.
        prod    = PROD_W'(smp) * PROD_W'($signed({1'b0, cur_gain}));
        term    = ACC_W'(prod >>> GAIN_FRAC);
        acc_ext = SAT_W'(acc_q);
        sat_v   = sat_to_width(acc_ext, SAMPLE_W);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    band_d  = band_in;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + term;
                idx_d = idx_q + AW'(1);
                if (32'(idx_q) == N_BANDS - 1) state_d = OUT;
            end
            OUT: begin
                audio_d     = SAMPLE_W'(sat_v);
                clip_d      = (sat_v != acc_ext);
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            band_q      <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            audio_q     <= '0;
            clip_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            band_q      <= band_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            audio_q     <= audio_d;
            clip_q      <= clip_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign audio_out = audio_q;
    assign out_valid = out_valid_q;
    assign clip      = clip_q;

endmodule

// File: tb/tb_eq_band_mixer.sv
// ---------------------------------------------------------------------------
// tb_eq_band_mixer : directed bench for eq_band_mixer. Two instances share
// all inputs: dut ramps gains by 16 per sample, dut0 jumps (RAMP_STEP=0).
// ---------------------------------------------------------------------------
module tb_eq_band_mixer;

    localparam int unsigned NB = 10;
    localparam int unsigned SW = 24;
    localparam int unsigned GW = 13;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NB*SW-1:0]       band_in;
    logic                   in_valid;
    logic                   gain_we;
    logic [3:0]             gain_addr;
    logic [GW-1:0]          gain_wdata;

    logic                   in_ready, out_valid, clip;
    logic signed [SW-1:0]   audio_out;
    logic                   in_ready0, out_valid0, clip0;
    logic signed [SW-1:0]   audio0;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    eq_band_mixer #(
        .N_BANDS(NB), .SAMPLE_W(SW), .GAIN_W(GW), .GAIN_FRAC(8), .RAMP_STEP(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .band_in(band_in), .in_valid(in_valid),
        .in_ready(in_ready), .gain_we(gain_we), .gain_addr(gain_addr),
        .gain_wdata(gain_wdata), .audio_out(audio_out), .out_valid(out_valid),
        .clip(clip)
    );

    eq_band_mixer #(
        .N_BANDS(NB), .SAMPLE_W(SW), .GAIN_W(GW), .GAIN_FRAC(8), .RAMP_STEP(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .band_in(band_in), .in_valid(in_valid),
        .in_ready(in_ready0), .gain_we(gain_we), .gain_addr(gain_addr),
        .gain_wdata(gain_wdata), .audio_out(audio0), .out_valid(out_valid0),
        .clip(clip0)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_all(input logic signed [SW-1:0] v);
        for (int k = 0; k < NB; k++) band_in[k*SW +: SW] = v;
    endtask

    task automatic set_band(input int k, input logic signed [SW-1:0] v);
        band_in[k*SW +: SW] = v;
    endtask

    task automatic write_gain(input logic [3:0] a, input logic [GW-1:0] d);
        gain_we    = 1'b1;
        gain_addr  = a;
        gain_wdata = d;
        @(posedge clk); #1;
        gain_we    = 1'b0;
    endtask

    // Called #1 after an edge with the DUT idle; offers one sample, then
    // waits (bounded) for the result and checks latency and values.
    task automatic send(input string tag, input int e, input int e0, input logic ec);
        int lat;
        lat = 0;
        chk({tag, " ready"}, in_ready, 1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        chk({tag, " latency"}, lat, NB + 1);
        chk({tag, " audio"},   audio_out, e);
        chk({tag, " clip"},    clip, ec);
        chk({tag, " ov0"},     out_valid0, 1);
        chk({tag, " audio0"},  audio0, e0);
    endtask

    initial begin
        int   accepts, outs, last_out, spurious;
        logic rdy;

        band_in    = '0;
        in_valid   = 1'b0;
        gain_we    = 1'b0;
        gain_addr  = '0;
        gain_wdata = '0;

        #3;
        chk("reset out_valid", out_valid, 0);
        chk("reset audio",     audio_out, 0);
        chk("reset clip",      clip, 0);
        chk("reset in_ready",  in_ready, 1);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // Unity gains: plain sum of the bands
        set_all(24'sd1000);
        send("sum1000", 10000, 10000, 1'b0);

        // Saturation in both directions
        set_all(24'sh7FFFFF);
        send("satpos", 8388607, 8388607, 1'b1);
        set_all(24'sh800000);
        send("satneg", -8388608, -8388608, 1'b1);

        // Out-of-range gain address is ignored
        write_gain(4'd10, 13'd0);
        set_all(24'sd1000);
        send("badaddr", 10000, 10000, 1'b0);

        // Band 3 gain 0.5: -1 floors to -1; -3 -> -1.5 floors to -2
        write_gain(4'd3, 13'd128);
        set_all(24'sd0);
        set_band(3, -24'sd1);
        for (int i = 0; i < 9; i++) send("floor1", -1, -1, 1'b0);
        set_band(3, -24'sd3);
        send("floor3", -2, -2, 1'b0);

        // Band 0 gain 2.0: dut ramps 16/sample, dut0 jumps
        set_band(3, 24'sd0);
        set_band(0, 24'sd4096);
        write_gain(4'd0, 13'd512);
        send("prime", 4096, 4096, 1'b0);
        for (int j = 1; j <= 16; j++) send("ramp", 4096 + 256 * j, 8192, 1'b0);
        for (int j = 0; j < 2; j++) send("hold", 8192, 8192, 1'b0);

        // in_valid held high for 100 cycles
        accepts  = 0;
        outs     = 0;
        last_out = -1;
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 130; cyc++) begin
            if (cyc == 100) in_valid = 1'b0;
            rdy = in_ready & in_valid;
            @(posedge clk); #1;
            if (rdy) accepts++;
            if (out_valid) begin
                chk("tput audio", audio_out, 8192);
                if (last_out >= 0) chk("tput gap", cyc - last_out, NB + 2);
                last_out = cyc;
                outs++;
            end
        end
        chk("tput accepts", accepts, 9);
        chk("tput outputs", outs, 9);

        // Reset in the middle of MAC
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("mac in_ready", in_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", out_valid, 0);
        chk("midrst in_ready",  in_ready, 1);
        chk("midrst audio",     audio_out, 0);
        chk("midrst clip",      clip, 0);
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid) spurious++;
        end
        chk("midrst no output", spurious, 0);
        send("postrst", 4096, 4096, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
